// File: rtl/sober_pkg.sv
// Shared types and constants for the Sobel pixel source.
package sober_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned IMG_W_DEF = 256;
  localparam int unsigned IMG_H_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sober_skid1.sv
// One-entry skid register: holds a returning pixel while the consumer stalls.
module sober_skid1
  import sober_pkg::*;
#(
  parameter int unsigned W = PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0] data_q;
  logic         full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (unload) begin
      full_q <= 1'b0;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/sober_pixel_src.sv
// Frame-read streaming source: reads one frame from a 1-cycle-latency RAM and
// emits it in raster order with sof/eol/eof markers, stallable via pause_i.
module sober_pixel_src
  import sober_pkg::*;
#(
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned IMG_H     = IMG_H_DEF,
  parameter int unsigned AW        = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [AW-1:0]    mem_addr_o,
  output logic             mem_rd_o,
  input  logic [PIX_W-1:0] mem_data_i,
  output logic [PIX_W-1:0] data_o,
  output logic             en_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = $clog2(NPIX + 1);
  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     rd_cnt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              inflight;
  logic              done_q;
  logic              issue;
  logic              start_ok;
  logic              skid_load, skid_unload, skid_full;
  logic [PIX_W-1:0]  skid_data;
  logic              last_x, last_y;

  sober_skid1 #(.W(PIX_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (mem_data_i),
    .dout   (skid_data),
    .full   (skid_full)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and read issue
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          start_ok  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!pause_i && !skid_full && (rd_cnt < CW'(NPIX))) begin
          issue = 1'b1;
          if (rd_cnt == CW'(NPIX - 1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (en_o && eof_o) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Delivery: skid has priority; a stalled returning read is parked in the skid
  always_comb begin
    en_o        = 1'b0;
    data_o      = '0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (skid_full && !pause_i) begin
      en_o        = 1'b1;
      data_o      = skid_data;
      skid_unload = 1'b1;
    end else if (inflight && !pause_i) begin
      en_o   = 1'b1;
      data_o = mem_data_i;
    end else if (inflight && pause_i) begin
      skid_load = 1'b1;
    end
  end

  // Read counter, raster position, in-flight flag and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      x        <= '0;
      y        <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= (state == ST_DONE);
      if (start_ok) begin
        rd_cnt <= '0;
        x      <= '0;
        y      <= '0;
      end else begin
        if (issue) rd_cnt <= rd_cnt + CW'(1);
        if (en_o) begin
          if (last_x) begin
            x <= '0;
            y <= last_y ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
    end
  end

  assign last_x     = (x == XW'(IMG_W - 1));
  assign last_y     = (y == YW'(IMG_H - 1));
  assign sof_o      = en_o && (x == '0) && (y == '0);
  assign eol_o      = en_o && last_x;
  assign eof_o      = eol_o && last_y;
  assign mem_rd_o   = issue;
  assign mem_addr_o = AW'(BASE_ADDR) + AW'(rd_cnt);
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_q;
  assign state_o    = state;

endmodule

// File: tb/tb_sober_pixel_src.sv
// Self-checking bench for sober_pixel_src against a raster-order frame model.
module tb_sober_pixel_src;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned AW   = 16;
  localparam int unsigned BASE = 16'h10;
  localparam int unsigned NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data = 8'h00;
  logic [7:0]    data;
  logic          en, sof, eol, eof, busy, done;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] cap_pix [32];
  int          cap_cyc [32];
  int          cap_n;
  int          done_cyc;
  int          viol;
  bit          timed_out;

  always #5 clk = ~clk;

  // RAM returns its own address as data, one cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

  sober_pixel_src #(.IMG_W(W), .IMG_H(H), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .pause_i    (pause),
    .mem_addr_o (mem_addr),
    .mem_rd_o   (mem_rd),
    .mem_data_i (mem_data),
    .data_o     (data),
    .en_o       (en),
    .sof_o      (sof),
    .eol_o      (eol),
    .eof_o      (eof),
    .busy_o     (busy),
    .done_o     (done),
    .state_o    (state)
  );

  // Frame model: pixel k of the raster is {value, sof, eol, eof}
  function automatic logic [10:0] exp_pix(input int k);
    logic [7:0] d;
    d = 8'(BASE + k);
    return {d, k == 0, (k % W) == W - 1, k == NPIX - 1};
  endfunction

  // Stimulus/capture: mode 0 none, 1 pause cyc 3-5, 2 pause cyc 9-11,
  // 3 random pause, 4 extra start pulses mid-frame
  task automatic run_frame(input int mode, input int maxcyc);
    cap_n = 0; done_cyc = -1; viol = 0; timed_out = 1'b1;
    for (int c = 0; c < maxcyc; c++) begin
      @(negedge clk);
      start = (c == 0) || (mode == 4 && (c == 4 || c == 6));
      case (mode)
        1:       pause = (c >= 3 && c <= 5);
        2:       pause = (c >= 9 && c <= 11);
        3:       pause = (c > 0) && ($urandom_range(2) == 0);
        default: pause = 1'b0;
      endcase
      #1;
      if (pause && (en || mem_rd)) viol++;
      if (en && cap_n < 32) begin
        cap_pix[cap_n] = {data, sof, eol, eof};
        cap_cyc[cap_n] = c;
        cap_n++;
      end
      if (done) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    #12 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({en, mem_rd, busy, done, state, data, sof, eol, eof, mem_addr} !==
          {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0010}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d en=%b rd=%b busy=%b done=%b st=%0d data=%h addr=%h",
                 c, en, mem_rd, busy, done, state, data, mem_addr);
      end
    end
  endtask

  task automatic test_stream();
    run_frame(0, 40);
    n_checks++;
    if (timed_out || cap_n !== NPIX) begin
      n_fail++; $display("FAIL stream_count got=%0d exp=%0d timeout=%b", cap_n, NPIX, timed_out);
    end
    for (int k = 0; k < cap_n && k < NPIX; k++) begin
      n_checks++;
      if (cap_pix[k] !== exp_pix(k)) begin
        n_fail++; $display("FAIL stream_pix%0d got=%h exp=%h", k, cap_pix[k], exp_pix(k));
      end
      n_checks++;
      if (cap_cyc[k] !== 2 + k) begin
        n_fail++; $display("FAIL stream_cycle%0d got=%0d exp=%0d", k, cap_cyc[k], 2 + k);
      end
    end
    n_checks++;
    if (cap_n > 0 && done_cyc !== cap_cyc[cap_n-1] + 2) begin
      n_fail++; $display("FAIL stream_done_cycle got=%0d exp=%0d", done_cyc, cap_cyc[cap_n-1] + 2);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stream_busy_at_done got=%b exp=0", busy);
    end
    @(negedge clk); start = 1'b0; pause = 1'b0; #1;
    n_checks++;
    if ({done, busy, state} !== 4'b0000) begin
      n_fail++; $display("FAIL stream_after_done got done=%b busy=%b st=%0d exp 0/0/0", done, busy, state);
    end
  endtask

  task automatic test_pause();
    run_frame(1, 60);
    n_checks++;
    if (timed_out || cap_n !== NPIX) begin
      n_fail++; $display("FAIL pause_count got=%0d exp=%0d timeout=%b", cap_n, NPIX, timed_out);
    end
    for (int k = 0; k < cap_n && k < NPIX; k++) begin
      n_checks++;
      if (cap_pix[k] !== exp_pix(k)) begin
        n_fail++; $display("FAIL pause_pix%0d got=%h exp=%h", k, cap_pix[k], exp_pix(k));
      end
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL pause_activity got=%0d exp=0", viol);
    end
    @(negedge clk); start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_pause_last();
    run_frame(2, 60);
    n_checks++;
    if (timed_out || cap_n !== NPIX) begin
      n_fail++; $display("FAIL plast_count got=%0d exp=%0d timeout=%b", cap_n, NPIX, timed_out);
    end
    for (int k = 0; k < cap_n && k < NPIX; k++) begin
      n_checks++;
      if (cap_pix[k] !== exp_pix(k)) begin
        n_fail++; $display("FAIL plast_pix%0d got=%h exp=%h", k, cap_pix[k], exp_pix(k));
      end
    end
    n_checks++;
    if (cap_n == NPIX && cap_cyc[NPIX-1] !== 12) begin
      n_fail++; $display("FAIL plast_eof_cycle got=%0d exp=12", cap_cyc[NPIX-1]);
    end
    n_checks++;
    if (done_cyc !== 14 || viol !== 0) begin
      n_fail++; $display("FAIL plast_done got=%0d viol=%0d exp=14 viol=0", done_cyc, viol);
    end
    @(negedge clk); start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_random_pause();
    for (int r = 0; r < 4; r++) begin
      run_frame(3, 200);
      n_checks++;
      if (timed_out || cap_n !== NPIX || viol !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_count got=%0d viol=%0d timeout=%b exp=%0d", r, cap_n, viol, timed_out, NPIX);
      end
      for (int k = 0; k < cap_n && k < NPIX; k++) begin
        n_checks++;
        if (cap_pix[k] !== exp_pix(k)) begin
          n_fail++; $display("FAIL rand%0d_pix%0d got=%h exp=%h", r, k, cap_pix[k], exp_pix(k));
        end
      end
      n_checks++;
      if (cap_n > 0 && done_cyc !== cap_cyc[cap_n-1] + 2) begin
        n_fail++; $display("FAIL rand%0d_done got=%0d exp=%0d", r, done_cyc, cap_cyc[cap_n-1] + 2);
      end
      @(negedge clk); start = 1'b0; pause = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      run_frame(r == 0 ? 4 : 0, 40);
      n_checks++;
      if (timed_out || cap_n !== NPIX) begin
        n_fail++; $display("FAIL b2b%0d_count got=%0d exp=%0d timeout=%b", r, cap_n, NPIX, timed_out);
      end
      for (int k = 0; k < cap_n && k < NPIX; k++) begin
        n_checks++;
        if (cap_pix[k] !== exp_pix(k)) begin
          n_fail++; $display("FAIL b2b%0d_pix%0d got=%h exp=%h", r, k, cap_pix[k], exp_pix(k));
        end
      end
    end
    @(negedge clk); start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_async_reset();
    int seen;
    seen = 0;
    pause = 1'b0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
      if (en) seen++;
    end
    n_checks++;
    if (seen !== 3) begin
      n_fail++; $display("FAIL areset_prefix got=%0d exp=3", seen);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({en, mem_rd, busy, state, data, mem_addr} !==
        {1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 16'h0010}) begin
      n_fail++;
      $display("FAIL areset_clear en=%b rd=%b busy=%b st=%0d data=%h addr=%h exp 0/0/0/0/00/0010",
               en, mem_rd, busy, state, data, mem_addr);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    run_frame(0, 40);
    n_checks++;
    if (timed_out || cap_n !== NPIX) begin
      n_fail++; $display("FAIL areset_count got=%0d exp=%0d timeout=%b", cap_n, NPIX, timed_out);
    end
    for (int k = 0; k < cap_n && k < NPIX; k++) begin
      n_checks++;
      if (cap_pix[k] !== exp_pix(k)) begin
        n_fail++; $display("FAIL areset_pix%0d got=%h exp=%h", k, cap_pix[k], exp_pix(k));
      end
    end
    @(negedge clk); start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pause();
    test_pause_last();
    test_random_pause();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sober_pixel_src.md
Name: sober_pixel_src

Overview:
- Frame-read streaming source that produces the 8-bit pixel stream `data`/`en` consumed by the Sobel top.
- On a start pulse it reads one IMG_W x IMG_H greyscale frame from a synchronous image RAM with 1-cycle read latency.
- It emits the pixels in raster order with row/frame markers.
- A pause input stalls the stream without losing or duplicating pixels.

Parameters:
- IMG_W, 256, pixels per row (>=2)
- IMG_H, 256, rows per frame (>=1)
- AW, 16, RAM address width; IMG_W*IMG_H + BASE_ADDR must fit in AW bits
- BASE_ADDR, 0, RAM address of pixel (0,0)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  1-cycle start pulse; accepted only in IDLE
- pause_i  in  1  consumer stall; while high, en_o must be 0
- mem_addr_o  out  AW  RAM read address
- mem_rd_o  out  1  RAM read strobe
- mem_data_i  in  8  RAM read data, valid the cycle after mem_rd_o
- data_o  out  8  pixel value
- en_o  out  1  data_o valid this cycle
- sof_o  out  1  with en_o: first pixel of frame
- eol_o  out  1  with en_o: last pixel of a row
- eof_o  out  1  with en_o: last pixel of frame
- busy_o  out  1  state != IDLE
- done_o  out  1  1-cycle pulse after last pixel is delivered
- state_o  out  2  current FSM state (debug / 7-segment)

Behaviour:
Reset:
- All registers clear: state IDLE, counters 0, skid buffer empty, in-flight flag 0.
- mem_rd_o=0, en_o=0, done_o=0, busy_o=0, state_o=0, mem_addr_o=BASE_ADDR, data_o=0.

FSM encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- IDLE: on start_i, clear rd_cnt, x, y and go to RUN. start_i in any other state is ignored.
- RUN: issue reads.
  - Issue condition: pause_i==0 AND skid empty AND rd_cnt < IMG_W*IMG_H.
  - On issue: mem_rd_o=1, mem_addr_o=BASE_ADDR+rd_cnt, then rd_cnt++ and set in-flight for the next cycle.
  - When the final read is issued, go to DRAIN.
- DRAIN: no reads. When the last pixel has been delivered (en_o with eof_o), go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.

Delivery (combinational outputs from the in-flight/skid registers):
- Skid full AND pause_i==0: en_o=1, data_o=skid; skid empties.
- Else, in-flight AND pause_i==0: en_o=1, data_o=mem_data_i.
- In-flight AND pause_i==1: capture mem_data_i into skid; en_o=0.
- Invariant: at most one read in flight plus one skid entry. The issue rule guarantees the skid and a returning read never conflict.

Markers and counters:
- x, y advance only on en_o. x wraps at IMG_W-1 and then y++.
- sof_o = en_o & x==0 & y==0.
- eol_o = en_o & x==IMG_W-1.
- eof_o = eol_o & y==IMG_H-1.

Throughput and latency:
- With pause_i held low, one pixel per cycle.
- First en_o occurs 2 cycles after start_i: start accepted, then read, then data.
- Pixel count per frame is exactly IMG_W*IMG_H.

Boundary cases:
- pause_i during DRAIN: the pending pixel is held in the skid; DONE waits for it.
- pause_i high for N cycles: no en_o in those cycles; the sequence resumes with no gap in values.
- Reset mid-frame: immediate return to IDLE; the in-flight read is discarded; the next start_i restarts at pixel (0,0).

Decomposition:
- Shared package `sober_pkg`:
  - state encoding constants ST_IDLE/ST_RUN/ST_DRAIN/ST_DONE, reused by the controller for state_o decode
  - PIX_W=8
  - default IMG_W/IMG_H
- One natural sub-module: `sober_skid1`, a 1-entry skid register with load/unload and full flag.
- Counters and FSM stay in the parent.

Test Plan (IMG_W=4, IMG_H=2, BASE_ADDR=0x10, RAM holds value = address):
1. rst high then low, no start -> all outputs 0, mem_addr_o=0x10, state_o=0 indefinitely.
2. start_i pulse, pause_i=0 -> en_o high 8 consecutive cycles.
   - data_o 0x10..0x17.
   - sof_o on 0x10; eol_o on 0x13 and 0x17; eof_o on 0x17.
   - done_o 2 cycles after the last pixel; busy_o low afterwards.
3. pause_i high on cycles 3-5 after start -> en_o low there; data_o still delivered 0x10..0x17 in order, no repeats; mem_rd_o never asserted while pause_i=1.
4. pause_i high in the cycle the last read returns -> that pixel (0x17) goes to the skid; it is delivered with eof_o when pause_i drops; done_o follows.
5. Second start_i mid-frame -> ignored, exactly 8 pixels delivered; a new start after done_o streams 0x10..0x17 again.
6. rst asserted asynchronously after 3 pixels -> outputs clear the same cycle; the following start streams from 0x10 with sof_o.
